mem_arbiter: RTL and testbench

//  Shares the single multi-cycle memory port between instruction fetch (IF, read-only) and the memory stage (DM, read/write).

---
 rtl/mem_arb_pkg.sv | 47 ++++
 rtl/arb_timer.sv | 38 +++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the memory-port arbiter. Holds the
//                3-bit state encoding, the default widths and limits, the
//                requester IDs and the arbitration helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Default parameter values
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_TIMEOUT    = 64;
  localparam int DEF_STARVE_LIM = 3;

  // State encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BUSY_IF = 3'd1;
  localparam logic [2:0] ST_BUSY_DM = 3'd2;
  localparam logic [2:0] ST_RESP_IF = 3'd3;
  localparam logic [2:0] ST_RESP_DM = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_BUSY_IF = ST_BUSY_IF,
    S_BUSY_DM = ST_BUSY_DM,
    S_RESP_IF = ST_RESP_IF,
    S_RESP_DM = ST_RESP_DM,
    S_ERR     = ST_ERR
  } arb_state_t;

  // Requester IDs
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // DM has priority unless IF has been passed over the maximum number of
  // times and is still waiting. Only meaningful when some request is high.
  function automatic logic pick_requester(input logic dm_req,
                                          input logic if_req,
                                          input logic at_lim);
    return (dm_req && !(at_lim && if_req)) ? REQ_DM : REQ_IF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : arb_timer
//  Description : Access watchdog. Down-counter loaded with TIMEOUT-1 and
//                decremented while enabled; 'expired' is high during the
//                TIMEOUT-th enabled cycle after a load.
//  Ports       : clk, rst (async, active-low), load, en -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_load_val = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one multi-cycle memory port between instruction fetch
//                (IF, read-only) and the memory stage (DM, read/write).
//                Each access: grant in IDLE, one-cycle mem_en, wait for
//                mem_done, then a one-cycle registered done pulse. Produces
//                per-requester stalls, drops flushed fetches and raises a
//                sticky error if memory never answers.
//  Ports       : clk, rst (async active-low)
//                IF side : if_req, if_addr, if_flush -> if_done, if_rdata
//                DM side : dm_req, dm_wr, dm_addr, dm_wdata -> dm_done, dm_rdata
//                Memory  : mem_done, mem_rdata -> mem_en, mem_wr, mem_addr,
//                          mem_wdata
//                Status  : stall_if, stall_dm, err
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIM);

  arb_state_t    r_state;
  logic [SW-1:0] r_starve;
  logic          r_discard;
  logic          r_acc_wr;   // current DM access is a write
  logic          r_if_done;

  logic w_busy;
  logic w_expired;
  logic w_grant_id;
  logic w_discard;

  assign w_busy     = (r_state == S_BUSY_IF) || (r_state == S_BUSY_DM);
  assign w_grant_id = pick_requester(dm_req, if_req, r_starve == c_starve_max);
  // A flush arriving in the same cycle as mem_done must already drop the result.
  assign w_discard  = r_discard || if_flush;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (r_state == S_IDLE),
    .en      (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_starve  <= '0;
      r_discard <= 1'b0;
      r_acc_wr  <= 1'b0;
      r_if_done <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      // Strobes are single-cycle by default
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      r_if_done <= 1'b0;
      dm_done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (dm_req || if_req) begin
            mem_en <= 1'b1;
            if (w_grant_id == REQ_DM) begin
              r_state   <= S_BUSY_DM;
              mem_wr    <= dm_wr;
              r_acc_wr  <= dm_wr;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (if_req && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
              end
            end else begin
              r_state   <= S_BUSY_IF;
              r_acc_wr  <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              r_starve  <= '0;
            end
          end
        end

        S_BUSY_IF: begin
          if (if_flush) begin
            r_discard <= 1'b1;
          end
          if (mem_done) begin
            r_state <= S_RESP_IF;
            if (!w_discard) begin
              if_rdata  <= mem_rdata;
              r_if_done <= 1'b1;
            end
          end else if (w_expired) begin
            r_state <= S_ERR;
            err     <= 1'b1;
          end
        end

        S_BUSY_DM: begin
          if (mem_done) begin
            r_state <= S_RESP_DM;
            dm_done <= 1'b1;
            if (!r_acc_wr) begin
              dm_rdata <= mem_rdata;
            end
          end else if (w_expired) begin
            r_state <= S_ERR;
            err     <= 1'b1;
          end
        end

        S_RESP_IF: begin
          r_state   <= S_IDLE;
          r_discard <= 1'b0;
        end

        S_RESP_DM: begin
          r_state <= S_IDLE;
        end

        S_ERR: begin
          // Locked until reset; no further memory traffic.
          err <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush during the response cycle withdraws the done pulse immediately.
  assign if_done  = r_if_done && !if_flush;

  // Stalls follow the request combinationally; gated by rst so every output
  // reads 0 while reset is held.
  assign stall_if = rst && if_req && !if_done;
  assign stall_dm = rst && dm_req && !dm_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Directed steps in one
//                initial block; expected memory accesses and responses are
//                queued when a request is driven and checked when the DUT
//                produces them. A behavioural memory answers mem_en after a
//                programmable latency with data = addr ^ 16'hA5A5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          stall_if;
  logic          stall_dm;
  logic          err;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (64),
    .STARVE_LIM (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .stall_if  (stall_if),
    .stall_dm  (stall_dm),
    .err       (err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t          exp_acc[$];
  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_dm[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_en    = 0;
  int mem_lat = 3;
  bit mem_off = 0;

  logic [DW-1:0] if_hold;
  logic [DW-1:0] dm_hold;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory
  initial begin : mem_model
    logic [DW-1:0] rd;
    logic          wr;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && !mem_off) begin
        rd = rd_model(mem_addr);
        wr = mem_wr;
        repeat (mem_lat) @(posedge clk);
        #1;
        mem_done  = 1'b1;
        mem_rdata = wr ? 16'hDEAD : rd;
        @(posedge clk);
        #1;
        mem_done  = 1'b0;
      end
    end
  end

  // Scoreboard monitors
  always @(negedge clk) begin : mon
    acc_t a;
    logic [DW-1:0] d;
    if (mem_en) begin
      n_en++;
      chk("acc_expected", exp_acc.size() != 0, 1);
      if (exp_acc.size() != 0) begin
        a = exp_acc.pop_front();
        chk("acc_addr", mem_addr, a.addr);
        chk("acc_wr", mem_wr, a.wr);
        if (a.wr) chk("acc_wdata", mem_wdata, a.wdata);
      end
    end
    if (if_done) begin
      chk("if_resp_expected", exp_if.size() != 0, 1);
      if (exp_if.size() != 0) begin
        d = exp_if.pop_front();
        chk("if_rdata", if_rdata, d);
      end
    end
    if (dm_done) begin
      chk("dm_resp_expected", exp_dm.size() != 0, 1);
      if (exp_dm.size() != 0) begin
        d = exp_dm.pop_front();
        chk("dm_rdata", dm_rdata, d);
      end
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0:       return mem_en;
      1:       return if_done;
      2:       return dm_done;
      default: return mem_done;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait at negedges for an event; returns the cycle it was seen.
  task automatic wait_ev(input int sel, input int bound, input string tag, output int at);
    bit seen;
    seen = 0;
    at   = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (sig(sel)) begin
        seen = 1;
        at   = cyc;
      end
    end
    chk({tag, "_seen"}, seen, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"},    mem_en, 0);
    chk({tag, "_mem_wr"},    mem_wr, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_done"},   if_done, 0);
    chk({tag, "_if_rdata"},  if_rdata, 0);
    chk({tag, "_dm_done"},   dm_done, 0);
    chk({tag, "_dm_rdata"},  dm_rdata, 0);
    chk({tag, "_stall_if"},  stall_if, 0);
    chk({tag, "_stall_dm"},  stall_dm, 0);
    chk({tag, "_err"},       err, 0);
  endtask

  initial begin : main
    int t_req, t_en, t_md, t_d, n_if, n_dm, n_en0;

    rst = 1'b0; if_req = 1'b1; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_hold = '0; dm_hold = '0;
    repeat (3) step();
    chk_all_zero("reset");
    if_req = 1'b0;
    step();
    rst = 1'b1;
    repeat (2) step();

    // ---- single IF read, memory answers 3 cycles after mem_en ----
    if_req = 1'b1; if_addr = 16'h0000; t_req = cyc;
    exp_acc.push_back('{addr: 16'h0000, wr: 1'b0, wdata: '0});
    exp_if.push_back(16'hA5A5);
    @(negedge clk);
    chk("t1_stall_idle", stall_if, 1);
    wait_ev(0, 5, "t1_mem_en", t_en);
    chk("t1_en_latency", t_en, t_req + 1);
    @(negedge clk);
    chk("t1_mem_en_pulse", mem_en, 0);
    wait_ev(3, 10, "t1_mem_done", t_md);
    chk("t1_md_latency", t_md, t_en + 3);
    chk("t1_stall_busy", stall_if, 1);
    wait_ev(1, 3, "t1_if_done", t_d);
    chk("t1_done_latency", t_d, t_md + 1);
    chk("t1_stall_done", stall_if, 0);
    step();
    if_req = 1'b0;
    if_hold = 16'hA5A5;
    step();

    // ---- IF and DM together: DM write first, IF in the IDLE after RESP_DM ----
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0010;
    exp_acc.push_back('{addr: 16'h0040, wr: 1'b1, wdata: 16'h1234});
    exp_acc.push_back('{addr: 16'h0010, wr: 1'b0, wdata: '0});
    exp_dm.push_back(dm_hold);
    exp_if.push_back(rd_model(16'h0010));
    wait_ev(0, 5, "t2_dm_en", t_en);
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_addr", mem_addr, 16'h0040);
    wait_ev(2, 10, "t2_dm_done", t_d);
    chk("t2_stall_if_wait", stall_if, 1);
    step();
    dm_req = 1'b0; dm_wr = 1'b0;
    wait_ev(0, 5, "t2_if_en", t_en);
    chk("t2_if_after_resp", t_en, t_d + 2);
    wait_ev(1, 10, "t2_if_done", t_d);
    step();
    if_req = 1'b0;
    if_hold = rd_model(16'h0010);
    step();

    // ---- starvation: DM held, IF held -> D D D I D ----
    mem_lat = 2;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
    if_req = 1'b1; if_addr = 16'h0200;
    for (int i = 0; i < 3; i++) exp_acc.push_back('{addr: 16'h0100, wr: 1'b0, wdata: '0});
    exp_acc.push_back('{addr: 16'h0200, wr: 1'b0, wdata: '0});
    exp_acc.push_back('{addr: 16'h0100, wr: 1'b0, wdata: '0});
    for (int i = 0; i < 4; i++) exp_dm.push_back(rd_model(16'h0100));
    exp_if.push_back(rd_model(16'h0200));
    n_if = 0; n_dm = 0;
    for (int c = 0; c < 200 && !(n_dm == 4 && n_if == 1); c++) begin
      @(negedge clk);
      if (if_done) n_if++;
      if (dm_done) n_dm++;
      step();
      if (n_if >= 1) if_req = 1'b0;
      if (n_dm >= 4) dm_req = 1'b0;
    end
    chk("t3_dm_count", n_dm, 4);
    chk("t3_if_count", n_if, 1);
    dm_hold = rd_model(16'h0100);
    if_hold = rd_model(16'h0200);
    repeat (3) step();
    chk("t3_acc_drained", exp_acc.size(), 0);

    // ---- flush during BUSY_IF ----
    mem_lat = 3;
    if_req = 1'b1; if_addr = 16'h0300;
    exp_acc.push_back('{addr: 16'h0300, wr: 1'b0, wdata: '0});
    wait_ev(0, 5, "t4_en", t_en);
    step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    wait_ev(3, 10, "t4_mem_done", t_md);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_if_done", if_done, 0);
    end
    chk("t4_rdata_kept", if_rdata, if_hold);
    step();
    // next fetch completes normally: back in IDLE with discard cleared
    if_req = 1'b1; if_addr = 16'h0400;
    exp_acc.push_back('{addr: 16'h0400, wr: 1'b0, wdata: '0});
    exp_if.push_back(rd_model(16'h0400));
    wait_ev(1, 15, "t4_refetch_done", t_d);
    step();
    if_req = 1'b0;
    if_hold = rd_model(16'h0400);
    step();

    // ---- flush during RESP_IF ----
    if_req = 1'b1; if_addr = 16'h0450;
    exp_acc.push_back('{addr: 16'h0450, wr: 1'b0, wdata: '0});
    wait_ev(3, 15, "t4b_mem_done", t_md);
    step();
    if_flush = 1'b1;
    @(negedge clk);
    chk("t4b_done_masked", if_done, 0);
    chk("t4b_rdata", if_rdata, rd_model(16'h0450));
    step();
    if_flush = 1'b0; if_req = 1'b0;
    if_hold = rd_model(16'h0450);
    step();

    // ---- timeout: no mem_done for 64 BUSY cycles ----
    mem_off = 1;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500;
    exp_acc.push_back('{addr: 16'h0500, wr: 1'b0, wdata: '0});
    wait_ev(0, 5, "t5_en", t_en);
    repeat (63) @(negedge clk);
    chk("t5_err_not_yet", err, 0);
    @(negedge clk);
    chk("t5_err_set", err, 1);
    chk("t5_stall_dm", stall_dm, 1);
    step();
    if_req = 1'b1; if_addr = 16'h0600;
    n_en0 = n_en;
    repeat (10) @(negedge clk);
    chk("t5_no_mem_en", n_en, n_en0);
    chk("t5_stall_if", stall_if, 1);
    chk("t5_err_sticky", err, 1);
    step();
    dm_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("t5_stall_dm_low", stall_dm, 0);

    // ---- reset clears ERR; then reset mid-BUSY_DM ----
    step();
    rst = 1'b0;
    #1;
    chk("t6_err_cleared", err, 0);
    step();
    rst = 1'b1;
    step();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0600; dm_wdata = 16'h5555;
    if_req = 1'b1; if_addr = 16'h0700;
    exp_acc.push_back('{addr: 16'h0600, wr: 1'b1, wdata: 16'h5555});
    wait_ev(0, 5, "t6_en", t_en);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    step();
    dm_req = 1'b0; dm_wr = 1'b0; if_req = 1'b0;
    if_hold = '0; dm_hold = '0;
    step();
    rst = 1'b1;
    mem_off = 0;
    step();
    if_req = 1'b1; if_addr = 16'h0700; t_req = cyc;
    exp_acc.push_back('{addr: 16'h0700, wr: 1'b0, wdata: '0});
    exp_if.push_back(rd_model(16'h0700));
    wait_ev(0, 5, "t6_fresh_en", t_en);
    chk("t6_fresh_latency", t_en, t_req + 1);
    wait_ev(1, 10, "t6_fresh_done", t_d);
    step();
    if_req = 1'b0;
    repeat (3) step();

    chk("end_acc_empty", exp_acc.size(), 0);
    chk("end_if_empty", exp_if.size(), 0);
    chk("end_dm_empty", exp_dm.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
